dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester data-memory arbiter with lock-based ownership.
// Ports: clk, rst (async, active-high); per requester x in {a,b}:
//   x_req, x_we, x_lock, x_addr, x_wdata in; x_gnt, x_rvalid, x_rdata out.
//   Memory side: mem_addr, mem_write_data, mem_read, mem_write out,
//   mem_read_data in (combinational read).
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking,
//   otherwise requester A wins every tie.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } state_t;

    state_t            state_q, state_d;
    logic              a_gnt_c, b_gnt_c;
    logic              tie_to_a;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

`ifdef DMEM_ARB_RR_EN
    // Remembers who won last; a tie goes to the other requester.
    logic last_b_q, last_b_d;

    assign tie_to_a = last_b_q;

    always_comb begin
        last_b_d = last_b_q;
        if (b_gnt_c) begin
            last_b_d = 1'b1;
        end else if (a_gnt_c) begin
            last_b_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`else
    assign tie_to_a = 1'b1;
`endif

    // Grant and next state. Grants are held low during reset so no
    // stray write can reach memory while the block is being cleared.
    always_comb begin
        a_gnt_c = 1'b0;
        b_gnt_c = 1'b0;
        state_d = state_q;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (a_req && b_req) begin
                        a_gnt_c = tie_to_a;
                        b_gnt_c = !tie_to_a;
                    end else begin
                        a_gnt_c = a_req;
                        b_gnt_c = b_req;
                    end
                    if (a_gnt_c && a_lock) begin
                        state_d = OWN_A;
                    end else if (b_gnt_c && b_lock) begin
                        state_d = OWN_B;
                    end
                end
                OWN_A: begin
                    a_gnt_c = a_req;
                    if (!a_lock) begin
                        state_d = IDLE;
                    end
                end
                OWN_B: begin
                    b_gnt_c = b_req;
                    if (!b_lock) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Memory command mux; all zero when nobody holds a grant.
    always_comb begin
        mem_addr       = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        if (a_gnt_c) begin
            mem_addr       = a_addr;
            mem_write_data = a_wdata;
            mem_read       = a_req & ~a_we;
            mem_write      = a_req & a_we;
        end else if (b_gnt_c) begin
            mem_addr       = b_addr;
            mem_write_data = b_wdata;
            mem_read       = b_req & ~b_we;
            mem_write      = b_req & b_we;
        end
    end

    // Read responses: capture at the granting edge, valid one cycle.
    always_comb begin
        a_rvalid_d = a_gnt_c & ~a_we;
        b_rvalid_d = b_gnt_c & ~b_we;
        a_rdata_d  = a_rvalid_d ? mem_read_data : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? mem_read_data : b_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_gnt    = a_gnt_c;
    assign b_gnt    = b_gnt_c;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a word-array
// memory, directed scenarios followed by randomized traffic.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 0, a_we = 0, a_lock = 0;
    logic [31:0] a_addr = 0, a_wdata = 0;
    logic        b_req = 0, b_we = 0, b_lock = 0;
    logic [31:0] b_addr = 0, b_wdata = 0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock),
        .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock),
        .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Environment memory: 64 words, reloaded with a pattern during reset.
    logic [31:0] dmem [0:63];
    assign mem_read_data = dmem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'hA500_0000 | 32'(i);
        end else if (mem_write) begin
            dmem[mem_addr[7:2]] <= mem_write_data;
        end
    end

    typedef struct {
        logic        ga, gb, mr, mw, rva, rvb;
        logic [31:0] ma, mwd, rda, rdb;
    } exp_t;

    exp_t        cmd_q[$];
    logic [31:0] rsp_a_q[$];
    logic [31:0] rsp_b_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state.
    int          owner;
    bit          last_b;
    logic        m_rva, m_rvb;
    logic [31:0] m_rda, m_rdb;
    logic [31:0] ref_mem [0:63];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        owner  = 0;
        last_b = 1'b1;
        m_rva  = 1'b0;
        m_rvb  = 1'b0;
        m_rda  = '0;
        m_rdb  = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
        rsp_a_q.delete();
        rsp_b_q.delete();
    endtask

    // One bus cycle: drive inputs, predict outputs, then advance model.
    task automatic cycle(input bit ar, input bit aw, input bit al,
                         input logic [31:0] aa, input logic [31:0] ad,
                         input bit br, input bit bw, input bit bl,
                         input logic [31:0] ba, input logic [31:0] bd);
        bit   ga, gb;
        exp_t e;
        @(posedge clk);
        #1;
        a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
        ga = 0;
        gb = 0;
        if (owner == 1) ga = ar;
        else if (owner == 2) gb = br;
        else if (ar && br) begin
`ifdef DMEM_ARB_RR_EN
            ga = last_b;
`else
            ga = 1'b1;
`endif
            gb = !ga;
        end else begin
            ga = ar;
            gb = br;
        end
        e.ga  = ga;
        e.gb  = gb;
        e.ma  = ga ? aa : gb ? ba : 32'h0;
        e.mwd = ga ? ad : gb ? bd : 32'h0;
        e.mw  = (ga && aw) || (gb && bw);
        e.mr  = (ga && !aw) || (gb && !bw);
        e.rva = m_rva;
        e.rvb = m_rvb;
        e.rda = m_rda;
        e.rdb = m_rdb;
        cmd_q.push_back(e);
        m_rva = 1'b0;
        m_rvb = 1'b0;
        if (ga) begin
            if (aw) ref_mem[aa[7:2]] = ad;
            else begin
                m_rva = 1'b1;
                m_rda = ref_mem[aa[7:2]];
                rsp_a_q.push_back(m_rda);
            end
        end
        if (gb) begin
            if (bw) ref_mem[ba[7:2]] = bd;
            else begin
                m_rvb = 1'b1;
                m_rdb = ref_mem[ba[7:2]];
                rsp_b_q.push_back(m_rdb);
            end
        end
        if (owner == 1) begin
            if (!al) owner = 0;
        end else if (owner == 2) begin
            if (!bl) owner = 0;
        end else if (ga && al) owner = 1;
        else if (gb && bl) owner = 2;
        if (ga) last_b = 1'b0;
        if (gb) last_b = 1'b1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: per-cycle command check and read-response scoreboard.
    exp_t mon_e;
    always @(negedge clk) begin
        if (cmd_q.size() > 0) begin
            mon_e = cmd_q.pop_front();
            chk("a_gnt", 32'(a_gnt), 32'(mon_e.ga));
            chk("b_gnt", 32'(b_gnt), 32'(mon_e.gb));
            chk("mem_read", 32'(mem_read), 32'(mon_e.mr));
            chk("mem_write", 32'(mem_write), 32'(mon_e.mw));
            chk("mem_addr", mem_addr, mon_e.ma);
            chk("mem_wdata", mem_write_data, mon_e.mwd);
            chk("a_rvalid", 32'(a_rvalid), 32'(mon_e.rva));
            chk("b_rvalid", 32'(b_rvalid), 32'(mon_e.rvb));
            chk("a_rdata", a_rdata, mon_e.rda);
            chk("b_rdata", b_rdata, mon_e.rdb);
        end
        if (a_rvalid === 1'b1) begin
            if (rsp_a_q.size() == 0) chk("a_rsp_extra", 32'(a_rvalid), 0);
            else chk("a_rsp", a_rdata, rsp_a_q.pop_front());
        end
        if (b_rvalid === 1'b1) begin
            if (rsp_b_q.size() == 0) chk("b_rsp_extra", 32'(b_rvalid), 0);
            else chk("b_rsp", b_rdata, rsp_b_q.pop_front());
        end
    end

    initial begin
        model_reset();
        #12;
        chk("rst_a_gnt", 32'(a_gnt), 0);
        chk("rst_a_rvalid", 32'(a_rvalid), 0);
        chk("rst_b_rvalid", 32'(b_rvalid), 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        @(negedge clk);
        rst = 1'b0;

        // Nothing requested: quiet memory bus.
        repeat (2) idle();

        // Both read for four cycles.
        repeat (4) cycle(1, 0, 0, 32'h30, 0, 1, 0, 0, 32'h34, 0);

        // Write then read back.
        cycle(1, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        idle();

        // B holds ownership while A waits.
        cycle(0, 0, 0, 0, 0, 1, 0, 1, 32'h40, 0);
        cycle(1, 0, 0, 32'h44, 0, 1, 0, 1, 32'h48, 0);
        cycle(1, 0, 0, 32'h44, 0, 1, 1, 1, 32'h4C, 32'h1234);
        cycle(1, 0, 0, 32'h44, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 32'h44, 0, 0, 0, 0, 0, 0);
        idle();

        // Back-to-back reads.
        cycle(1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 32'h24, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        // Reset lands mid-cycle while B's read response is showing.
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 32'h14, 0);
        @(posedge clk);
        #1;
        a_req = 1; a_we = 1; a_addr = 32'h18; a_wdata = 32'hBAD0BAD0;
        b_req = 0;
        chk("pre_rst_b_rvalid", 32'(b_rvalid), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_b_rvalid", 32'(b_rvalid), 0);
        chk("async_b_rdata", b_rdata, 0);
        chk("rst_gnt_a", 32'(a_gnt), 0);
        chk("rst_strobe", 32'(mem_write), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_req = 0; a_we = 0;
        model_reset();
        rst = 1'b0;
        cycle(1, 0, 0, 32'h14, 0, 1, 0, 1, 32'h14, 0);
        idle();

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0,
                  32'($urandom_range(0, 63)) << 2, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0,
                  32'($urandom_range(0, 63)) << 2, $urandom);
        end
        repeat (4) idle();
        @(negedge clk);
        #1;
        chk("cmd_q_drain", 32'(cmd_q.size()), 0);
        chk("rsp_a_drain", 32'(rsp_a_q.size()), 0);
        chk("rsp_b_drain", 32'(rsp_b_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
